// File: rtl/core0_pkg.sv
// Shared definitions for the core0 multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU operations, immediate formats and the two small helpers the datapath uses.
package core0_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} mc_state_e;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_fmt_e;

    function automatic logic [31:0] build_imm(input imm_fmt_e fmt, input logic [31:0] ir);
        logic [31:0] imm;
        case (fmt)
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core0_mc_decode.sv
// Combinational instruction decoder: classifies the latched instruction word and flags
// anything outside the supported subset as illegal.
module core0_mc_decode
    import core0_pkg::*;
(
    input  logic [31:0] ir,
    output alu_op_e     alu_op,
    output imm_fmt_e    imm_fmt,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jal,
    output logic        reg_write,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opcode        = ir[6:0];
    assign f3            = ir[14:12];
    assign f7            = ir[31:25];
    assign unused_fields = ^{ir[24:15], ir[11:7]};

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case leaves a latch.
        alu_op    = ALU_ADD;
        imm_fmt   = IMM_I;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                is_load   = 1'b1;
                reg_write = 1'b1;
                illegal   = (f3 != 3'b010);
            end
            OP_STORE: begin
                is_store = 1'b1;
                imm_fmt  = IMM_S;
                illegal  = (f3 != 3'b010);
            end
            OP_IMM, OP_REG: begin
                reg_write = 1'b1;
                case (f3)
                    3'b000:  alu_op = (opcode == OP_REG && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
                // Only sub may carry a non-zero funct7 among the register-register ops.
                if (opcode == OP_REG && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000)))
                    illegal = 1'b1;
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                imm_fmt   = IMM_B;
                illegal   = (f3[2:1] != 2'b00);
            end
            OP_JAL: begin
                is_jal    = 1'b1;
                reg_write = 1'b1;
                imm_fmt   = IMM_J;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core0_multicycle.sv
// Multi-cycle RV32I-subset core with one shared req/ready memory port.
// Build option CORE0_RETIRE_CNT_EN enables the retired-instruction counter on retire_cnt.
module core0_multicycle
    import core0_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          NREGS     = 32,
    parameter int          XLEN      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        halted,
    output logic [31:0] retire_cnt
);

    localparam int RW = $clog2(NREGS);

    if (XLEN != 32) begin : g_bad_xlen
        $error("core0_multicycle: XLEN must be 32");
    end
    if (NREGS != 32 && NREGS != 16) begin : g_bad_nregs
        $error("core0_multicycle: NREGS must be 32 or 16");
    end

    mc_state_e   state;
    logic [31:0] pc, ir, a_q, b_q, imm_q, addr_q, res_q;
    logic [31:0] regs [NREGS];

    alu_op_e  alu_op;
    imm_fmt_e imm_fmt;
    logic     is_load, is_store, is_branch, is_jal, reg_write, illegal;

    core0_mc_decode u_decode (
        .ir        (ir),
        .alu_op    (alu_op),
        .imm_fmt   (imm_fmt),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    logic [RW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic          is_reg, uses_rs2, bad_reg, taken;
    logic [31:0]   alu_res, tgt;

    assign rs1_idx  = ir[15 +: RW];
    assign rs2_idx  = ir[20 +: RW];
    assign rd_idx   = ir[7 +: RW];
    assign is_reg   = (ir[6:0] == OP_REG);
    assign uses_rs2 = is_store || is_branch || is_reg;
    // RV32E: any referenced register above x15 is an illegal instruction.
    assign bad_reg  = (NREGS == 16) &&
                      ((reg_write && ir[11]) || (!is_jal && ir[19]) || (uses_rs2 && ir[24]));
    assign alu_res  = alu(alu_op, a_q, is_reg ? b_q : imm_q);
    assign tgt      = pc + imm_q;
    assign taken    = is_branch && ((a_q == b_q) ^ ir[12]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_VEC;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            addr_q <= '0;
            res_q  <= '0;
        end else begin
            // NOTE: state is updated with <= so every branch sees the pre-edge values.
            case (state)
                FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    state <= DECODE;
                end
                DECODE: if (illegal || bad_reg) begin
                    state <= TRAP;
                end else begin
                    a_q   <= regs[rs1_idx];
                    b_q   <= regs[rs2_idx];
                    imm_q <= build_imm(imm_fmt, ir);
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_branch) begin
                        if (taken && tgt[1]) state <= TRAP;
                        else begin
                            pc    <= taken ? tgt : pc + 32'd4;
                            state <= FETCH;
                        end
                    end else if (is_jal) begin
                        if (tgt[1]) state <= TRAP;
                        else begin
                            pc    <= tgt;
                            res_q <= pc + 32'd4;
                            state <= WB;
                        end
                    end else if (is_load || is_store) begin
                        if (alu_res[1:0] != 2'b00) state <= TRAP;
                        else begin
                            addr_q <= alu_res;
                            pc     <= pc + 32'd4;
                            state  <= MEM;
                        end
                    end else begin
                        res_q <= alu_res;
                        pc    <= pc + 32'd4;
                        state <= WB;
                    end
                end
                MEM: if (mem_ready) begin
                    if (is_load) begin
                        res_q <= mem_rdata;
                        state <= WB;
                    end else begin
                        state <= FETCH;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is reset explicitly because all registers must read 0 after reset.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == WB && reg_write && rd_idx != '0) begin
            regs[rd_idx] <= res_q;
        end
    end

    // rst_n gates the request so a pending transaction is withdrawn the moment reset asserts.
    assign mem_req   = rst_n && (state == FETCH || state == MEM);
    assign mem_we    = rst_n && (state == MEM) && is_store;
    assign mem_wdata = mem_we ? b_q : '0;
    assign halted    = (state == TRAP);

    always_comb begin
        mem_addr = '0;
        if (rst_n && state == FETCH) mem_addr = pc;
        else if (rst_n && state == MEM) mem_addr = addr_q;
    end

`ifdef CORE0_RETIRE_CNT_EN
    logic        retire;
    logic [31:0] retire_q;

    assign retire = (state == EXEC && is_branch && !(taken && tgt[1])) ||
                    (state == MEM && mem_ready && is_store) ||
                    (state == WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_q <= '0;
        else if (retire) retire_q <= retire_q + 32'd1;
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_core0_multicycle.sv
// Directed self-checking bench for core0_multicycle: small hand-assembled programs run
// against a behavioural memory with configurable ready latency.
module tb_core0_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_cnt;

    always #5 clk = ~clk;

    core0_multicycle #(.RESET_VEC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

`ifdef CORE0_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        logic [31:0] ret;
    } xact_t;

    logic [31:0] mem [64];
    xact_t       reads[$];
    xact_t       writes[$];
    int          cyc = 0;
    int          lat = 0;
    bit          hold_we = 1'b0;
    bit          chk_stable = 1'b0;
    int          wcnt = 0;
    logic [31:0] sv_addr = '0;
    logic        sv_we = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(imm, rs1, 3'b010, rd, 7'h03);
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] rd_addr(input int i);
        if (i < reads.size()) return reads[i].addr;
        return 32'hBAD0_0000;
    endfunction
    function automatic logic [31:0] rd_gap(input int i);
        if (i + 1 < reads.size()) return 32'(reads[i + 1].cyc - reads[i].cyc);
        return 32'hBAD0_0001;
    endfunction
    function automatic logic [31:0] wr_addr(input int i);
        if (i < writes.size()) return writes[i].addr;
        return 32'hBAD0_0002;
    endfunction
    function automatic logic [31:0] wr_data(input int i);
        if (i < writes.size()) return writes[i].data;
        return 32'hBAD0_0003;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Memory responder: decides ready for the upcoming edge and commits the transfer.
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end else begin
            if (chk_stable && wcnt > 0) begin
                check("stable_addr", mem_addr, sv_addr);
                check("stable_we", 32'(mem_we), 32'(sv_we));
            end
            if ((hold_we && mem_we) || wcnt < lat) begin
                mem_ready = 1'b0;
                wcnt++;
                sv_addr = mem_addr;
                sv_we   = mem_we;
            end else begin
                mem_ready = 1'b1;
                wcnt      = 0;
                if (mem_we) begin
                    mem[mem_addr[7:2]] = mem_wdata;
                    writes.push_back('{mem_addr, mem_wdata, cyc, retire_cnt});
                end else begin
                    mem_rdata = mem[mem_addr[7:2]];
                    reads.push_back('{mem_addr, mem_rdata, cyc, retire_cnt});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic start(input int l);
        rst_n = 1'b0;
        lat = l;
        hold_we = 1'b0;
        chk_stable = 1'b0;
        tick(2);
        reads.delete();
        writes.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int quiet;
        int waited;
        mem_ready = 1'b0;
        mem_rdata = '0;
        clear_mem();
        tick(2);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retire", retire_cnt, 32'd0);

        // ALU ops, ready tied high
        clear_mem();
        mem[0] = addi(1, 0, 5);
        mem[1] = addi(2, 0, -3);
        mem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
        mem[3] = enc_r(7'h00, 1, 2, 3'b010, 4);
        mem[4] = sw(3, 0, 32'h40);
        mem[5] = sw(4, 0, 32'h44);
        mem[6] = enc_b(0, 0, 0, 3'b000);
        start(0);
        tick(40);
        for (int i = 0; i < 7; i++) check("alu_fetch_addr", rd_addr(i), 32'(4 * i));
        for (int i = 0; i < 5; i++) check("alu_latency", rd_gap(i), 32'd4);
        check("branch_latency", rd_gap(6), 32'd3);
        check("add_result", wr_data(0), 32'd2);
        check("add_store_addr", wr_addr(0), 32'h40);
        check("slt_result", wr_data(1), 32'd1);
        check("retire_cnt_6", (reads.size() > 6) ? reads[6].ret : 32'hBAD0_0004,
              CNT_EN ? 32'd6 : 32'd0);

        // Memory ops with 2-cycle ready
        clear_mem();
        mem[0]  = jal(0, 32'h30);
        mem[12] = addi(1, 0, 5);
        mem[13] = sw(1, 0, 8);
        mem[14] = lw(5, 0, 8);
        mem[15] = sw(5, 0, 32'h44);
        mem[16] = enc_b(0, 0, 0, 3'b000);
        start(1);
        chk_stable = 1'b1;
        tick(80);
        chk_stable = 1'b0;
        check("sw_addr", wr_addr(0), 32'h8);
        check("sw_data", wr_data(0), 32'd5);
        check("lw_addr", rd_addr(4), 32'h8);
        check("lw_result_addr", wr_addr(1), 32'h44);
        check("lw_result", wr_data(1), 32'd5);

        // Branches, jal link and x0
        clear_mem();
        mem[0]  = addi(0, 0, 7);
        mem[1]  = jal(0, 32'h1C);
        mem[8]  = jal(1, -16);
        mem[4]  = enc_b(8, 0, 0, 3'b000);
        mem[6]  = sw(1, 0, 32'h80);
        mem[7]  = sw(0, 0, 32'h84);
        mem[33] = 32'hDEAD_BEEF;
        start(0);
        tick(40);
        check("jal_target", rd_addr(2), 32'h20);
        check("jal_back", rd_addr(3), 32'h10);
        check("jal_latency", rd_gap(2), 32'd4);
        check("beq_taken", rd_addr(4), 32'h18);
        check("beq_latency", rd_gap(3), 32'd3);
        check("jal_link", wr_data(0), 32'h24);
        check("x0_reads_zero", wr_data(1), 32'h0);

        mem[4] = enc_b(8, 0, 0, 3'b001);
        mem[5] = enc_b(0, 0, 0, 3'b000);
        start(0);
        tick(30);
        check("bne_not_taken", rd_addr(4), 32'h14);
        check("bne_latency", rd_gap(3), 32'd3);

        // Misaligned load address traps
        clear_mem();
        mem[0] = addi(1, 0, 6);
        mem[1] = lw(2, 1, 0);
        start(0);
        tick(15);
        check("lw_misalign_halt", 32'(halted), 32'd1);
        quiet = 0;
        repeat (12) begin
            tick(1);
            #1;
            if (mem_req !== 1'b0 || halted !== 1'b1) quiet++;
        end
        check("trap_sticky_quiet", 32'(quiet), 32'd0);
        check("trap_no_access", 32'(reads.size()), 32'd2);
        check("trap_retire", retire_cnt, CNT_EN ? 32'd1 : 32'd0);

        // Undefined opcode and misaligned jump target
        clear_mem();
        mem[0] = 32'h0000_007F;
        start(0);
        tick(10);
        check("illegal_halt", 32'(halted), 32'd1);
        check("illegal_fetches", 32'(reads.size()), 32'd1);

        clear_mem();
        mem[0] = jal(0, 2);
        start(0);
        tick(10);
        check("jal_misalign_halt", 32'(halted), 32'd1);

        // Reset while a store waits for ready
        clear_mem();
        mem[0] = sw(0, 0, 32'h40);
        start(0);
        hold_we = 1'b1;
        waited = 0;
        while (!(mem_req && mem_we) && waited < 20) begin
            tick(1);
            waited++;
        end
        check("store_pending", 32'(mem_req && mem_we), 32'd1);
        tick(3);
        check("store_held", 32'(mem_req), 32'd1);
        check("store_not_done", 32'(writes.size()), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(mem_req), 32'd0);
        check("async_we_drop", 32'(mem_we), 32'd0);
        hold_we = 1'b0;
        tick(2);
        reads.delete();
        rst_n = 1'b1;
        tick(3);
        check("first_fetch_vec", rd_addr(0), 32'h0);
        check("post_rst_halted", 32'(halted), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core0_multicycle.md
Name: core0_multicycle

Overview:
- Parametrised multi-cycle RV32I-subset core. Successor to the single-cycle core.
- Replaces the separate instruction and data memories with one shared memory port using a req/ready handshake.
- Adds an FSM sequencer, branch and jump support, R-type ops, and a trap/halt state.
- Sits at SoC top; connects to a unified memory or bus bridge.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, number of architectural registers; legal values 32 (RV32I) or 16 (RV32E). With 16, register index bit 4 set → trap.
- XLEN, 32, datapath width; only 32 is legal, elaboration-time assertion otherwise.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_ready  in  1  request accepted/completed this cycle.
- mem_rdata  in  32  read data; valid when mem_req && mem_ready && !mem_we.
- halted  out  1  core in TRAP state.
- retire_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset values: pc=RESET_VEC, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, retire_cnt=0, all regs=0.
- States: FETCH → DECODE → EXEC → {MEM, WB, FETCH}; MEM → {WB, FETCH}; any → TRAP.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready=1, then latch ir. mem_req is combinational from state; it drops the cycle after the handshake.
- DECODE: read rs1/rs2 into A/B; build immediate (I/S/B/J formats). Undefined opcode or funct → TRAP.
- Supported instructions: lw, sw, addi, andi, ori, slti, add, sub, and, or, slt, beq, bne, jal.
- EXEC, ALU ops: result = A op (B or imm).
- EXEC, beq/bne: on taken, pc←pc+immB; otherwise pc←pc+4. Then → FETCH.
- EXEC, jal: pc←pc+immJ; link pc_old+4 held for WB.
- EXEC, lw/sw: addr=A+imm. If addr[1:0]≠0 → TRAP, otherwise → MEM.
- EXEC, all other non-branch ops: pc←pc+4.
- Target misalignment: a branch or jump target with bit[1]=1 → TRAP.
- MEM: mem_req=1, mem_we=(sw), mem_addr=addr, mem_wdata=B. Hold stable until mem_ready.
- MEM exit: sw → FETCH; lw latches mem_rdata → WB.
- WB: write rd if rd≠0, then → FETCH. x0 always reads 0; writes to x0 are discarded.
- Latency with mem_ready tied high: branch 3, sw 4, ALU/jal 4, lw 5 cycles.
- TRAP: halted=1, mem_req=0. Sticky until rst_n.
- Retire: an instruction retires on the cycle it leaves its last state (EXEC, MEM or WB) for FETCH.
- Arithmetic: 32-bit wrap-around. slt/slti compare signed.
- PC overflow: pc 32'hFFFF_FFFC + 4 wraps to 0 without trap.
- Reset mid-transaction: mem_req deasserts immediately (async). The memory must discard an un-acknowledged request.
- mem_ready while mem_req=0: ignored.

Optional Feature:
- Macro: CORE0_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 per retired instruction, wraps at 2^32, is cleared by reset, and does not count while in TRAP.
- Undefined: retire_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package core0_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_BRANCH, OP_JAL)
  - alu_op_e enum
  - mc_state_e enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - imm_fmt_e enum
- Sub-module core0_mc_decode: combinational ir → alu_op, imm_fmt, is_load/is_store/is_branch/is_jal/reg_write, illegal.
- FSM, datapath and register file stay in the top module.

Test Plan:
- ALU ops, mem_ready tied 1. Program addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1 → x3=2, x4=1. Each instruction completes in 4 cycles.
- Memory ops with a 2-cycle-ready memory. sw x1,8(x0) then lw x5,8(x0) → write of 5 to addr 8 observed on the port; x5=5. mem_addr/mem_we stay stable while ready is low.
- Branch. beq x0,x0,+8 at pc=0x10 → next fetch address 0x18. bne x0,x0,+8 → next fetch 0x14.
- Jump and x0. jal x1,-16 at 0x20 → x1=0x24, next fetch 0x10. addi x0,x0,7 → x0 still reads 0.
- Traps. lw with addr=0x6 → halted=1, mem_req stays 0 for ≥10 cycles. Separately, opcode 7'h7F → halted=1.
- Reset. Drop rst_n mid-MEM with ready held low → mem_req=0 immediately; after release, the first fetch is at RESET_VEC. With CORE0_RETIRE_CNT_EN defined, 6 instructions retired → retire_cnt=6; undefined → retire_cnt=0.
